// File: rtl/mul_seq_ctrl.sv
// Sequential shift-add multiplier controller: unsigned 32x32 -> 64 product,
// one addition per RUN cycle through an external shared adder.
module mul_seq_ctrl #(
    parameter bit          EARLY_TERM = 1'b0,
    parameter int unsigned ITER       = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [63:0] p_o,
    output logic [31:0] add_a_o,
    output logic [31:0] add_b_o,
    output logic        add_sna_o,
    input  logic [31:0] add_y_i,
    input  logic        add_co_i
);

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = 6;
    localparam int unsigned SW = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic [W-1:0]    m_q, m_d;
    logic [W-1:0]    mq_q, mq_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W:0]      sum;
    logic [PW-1:0]   stepped;
    logic [PW-1:0]   early;
    logic [SW-1:0]   early_shamt;
    logic            last_step;
    logic            early_exit;

    // Datapath for one step: conditional add of M into HI, then 65-bit right shift.
    always_comb begin
        sum         = lo_q[0] ? {add_co_i, add_y_i} : {1'b0, hi_q};
        stepped     = {sum, lo_q[W-1:1]};
        early_shamt = SW'(W) - SW'(cnt_q);
        early       = {hi_q, lo_q} >> early_shamt;
        last_step   = (cnt_q == CW'(ITER - 1));
        early_exit  = EARLY_TERM && (mq_q == '0);
    end

    // Next-state and register update logic.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        mq_d    = mq_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    m_d     = a_i;
                    lo_d    = b_i;
                    mq_d    = b_i;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (early_exit) begin
                    // Remaining multiplier bits are zero: realign the partial product.
                    p_d     = early;
                    state_d = S_FIN;
                end else begin
                    {hi_d, lo_d} = stepped;
                    mq_d         = mq_q >> 1;
                    cnt_d        = cnt_q + CW'(1);
                    if (last_step) begin
                        p_d     = stepped;
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            mq_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            mq_q    <= mq_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Adder operands come straight from registers; the unit is only ever asked to add.
    assign add_a_o   = hi_q;
    assign add_b_o   = m_q;
    assign add_sna_o = 1'b0;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign p_o       = p_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and randomized checks of mul_seq_ctrl with and without early termination.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [31:0] a, b;

    logic        busy0, done0, sna0, co0;
    logic [63:0] p0;
    logic [31:0] adda0, addb0, y0;
    logic        busy1, done1, sna1, co1;
    logic [63:0] p1;
    logic [31:0] adda1, addb1, y1;

    always #5 clk = ~clk;

    // Shared adder models, one per instance.
    assign {co0, y0} = {1'b0, adda0} + {1'b0, addb0};
    assign {co1, y1} = {1'b0, adda1} + {1'b0, addb1};

    mul_seq_ctrl #(.EARLY_TERM(1'b0), .ITER(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .a_i(a), .b_i(b),
        .busy_o(busy0), .done_o(done0), .p_o(p0),
        .add_a_o(adda0), .add_b_o(addb0), .add_sna_o(sna0),
        .add_y_i(y0), .add_co_i(co0)
    );

    mul_seq_ctrl #(.EARLY_TERM(1'b1), .ITER(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .a_i(a), .b_i(b),
        .busy_o(busy1), .done_o(done1), .p_o(p1),
        .add_a_o(adda1), .add_b_o(addb1), .add_sna_o(sna1),
        .add_y_i(y1), .add_co_i(co1)
    );

    int checks = 0;
    int errors = 0;
    bit sna_bad = 1'b0;

    always @(negedge clk) if (sna0 !== 1'b0 || sna1 !== 1'b0) sna_bad = 1'b1;

    typedef struct {
        bit          et;
        logic [31:0] av;
        logic [31:0] bv;
        logic [63:0] pexp;
        int          lat;
    } vec_t;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic get_done(input bit et);
        return et ? done1 : done0;
    endfunction

    function automatic logic get_busy(input bit et);
        return et ? busy1 : busy0;
    endfunction

    function automatic logic [63:0] get_p(input bit et);
        return et ? p1 : p0;
    endfunction

    // Edge index (after the accept edge) at which FIN is entered.
    function automatic int ref_lat(input bit et, input logic [31:0] bv);
        int msb;
        if (!et) return 32;
        msb = -1;
        for (int i = 0; i < 32; i++) if (bv[i]) msb = i;
        if (msb < 0) return 1;
        return (msb + 2 > 32) ? 32 : msb + 2;
    endfunction

    // Start one run, wait for DONE, check product, latency, busy length and pulse width.
    task automatic run_one(input bit et, input logic [31:0] av, input logic [31:0] bv,
                           input logic [63:0] pexp, input int lat, input string name);
        int cyc;
        int busy_cnt;
        bit got;
        @(negedge clk);
        a = av; b = bv;
        if (et) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        cyc = 0; busy_cnt = 0; got = 1'b0;
        while (cyc <= 40) begin
            if (get_done(et)) begin
                got = 1'b1;
                break;
            end
            if (get_busy(et)) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        chkint({name, "_done_seen"}, int'(got), 1);
        if (got) begin
            chk64({name, "_p"}, get_p(et), pexp);
            chkint({name, "_latency"}, cyc, lat);
            chkint({name, "_busy_cycles"}, busy_cnt, lat);
            @(negedge clk);
            chkint({name, "_done_pulse"}, int'(get_done(et)), 0);
        end
    endtask

    // Same operands into both instances; each is checked against the reference.
    task automatic run_pair(input logic [31:0] av, input logic [31:0] bv);
        int cyc, l0, l1;
        bit g0, g1;
        logic [63:0] c0, c1, pexp;
        pexp = 64'(av) * 64'(bv);
        @(negedge clk);
        a = av; b = bv; start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        cyc = 0; g0 = 1'b0; g1 = 1'b0; l0 = -1; l1 = -1; c0 = '0; c1 = '0;
        while (cyc <= 33) begin
            if (done0 && !g0) begin g0 = 1'b1; l0 = cyc; c0 = p0; end
            else if (g0 && cyc == l0 + 1) chkint("rnd_done_pulse_et0", int'(done0), 0);
            if (done1 && !g1) begin g1 = 1'b1; l1 = cyc; c1 = p1; end
            else if (g1 && cyc == l1 + 1) chkint("rnd_done_pulse_et1", int'(done1), 0);
            @(negedge clk);
            cyc++;
        end
        chk64("rnd_p_et0", c0, pexp);
        chk64("rnd_p_et1", c1, pexp);
        chkint("rnd_lat_et0", l0, ref_lat(1'b0, bv));
        chkint("rnd_lat_et1", l1, ref_lat(1'b1, bv));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[12];
        int   cyc;
        bit   got;

        vecs[0]  = '{1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000F, 32};
        vecs[1]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32};
        vecs[2]  = '{1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 32};
        vecs[3]  = '{1'b0, 32'd0,          32'h1234_5678,  64'h0,                   32};
        vecs[4]  = '{1'b0, 32'hDEAD_BEEF,  32'h10,         64'h0000_000D_EADB_EEF0, 32};
        vecs[5]  = '{1'b1, 32'h1234_5678,  32'd1,          64'h0000_0000_1234_5678, 2};
        vecs[6]  = '{1'b1, 32'h1234_5678,  32'd0,          64'h0,                   1};
        vecs[7]  = '{1'b1, 32'd3,          32'h8000_0000,  64'h0000_0001_8000_0000, 32};
        vecs[8]  = '{1'b1, 32'd3,          32'd5,          64'h0000_0000_0000_000F, 4};
        vecs[9]  = '{1'b1, 32'h0001_0000,  32'h100,        64'h0000_0000_0100_0000, 10};
        vecs[10] = '{1'b1, 32'hDEAD_BEEF,  32'h10,         64'h0000_000D_EADB_EEF0, 6};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; a = '0; b = '0;
        #1;
        chk64("reset_p", p0, 64'h0);
        chkint("reset_busy", int'(busy0), 0);
        chkint("reset_done", int'(done0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++)
            run_one(vecs[i].et, vecs[i].av, vecs[i].bv, vecs[i].pexp, vecs[i].lat,
                    $sformatf("vec%0d", i));

        // START during RUN is ignored; operand changes after accept have no effect.
        @(negedge clk);
        a = 32'd3; b = 32'd5; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; a = '0; b = '0;
        cyc = 0; got = 1'b0;
        while (cyc <= 40) begin
            if (cyc == 10) begin a = 32'd7; b = 32'd9; start0 = 1'b1; end
            if (cyc == 11) start0 = 1'b0;
            if (done0) begin got = 1'b1; break; end
            @(negedge clk);
            cyc++;
        end
        chkint("ignore_done_seen", int'(got), 1);
        chkint("ignore_latency", cyc, 32);
        chk64("ignore_p", p0, 64'd15);
        repeat (5) @(negedge clk);
        chk64("hold_p", p0, 64'd15);
        chkint("hold_idle_busy", int'(busy0), 0);
        run_one(1'b0, 32'd7, 32'd9, 64'd63, 32, "restart");

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a = 32'd3; b = 32'd5; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk64("run_add_b", 64'(addb0), 64'd3);
        chk64("run_add_a", 64'(adda0), 64'd0);
        repeat (5) @(negedge clk);
        chk64("p_kept_at_start", p0, 64'd63);
        repeat (9) @(negedge clk);
        chkint("mid_run_busy", int'(busy0), 1);
        #2 rst_n = 1'b0;
        #1;
        chkint("async_rst_busy", int'(busy0), 0);
        chkint("async_rst_done", int'(done0), 0);
        chk64("async_rst_p", p0, 64'h0);
        chk64("async_rst_add_a", 64'(adda0), 64'h0);
        chk64("async_rst_add_b", 64'(addb0), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(1'b0, 32'd2, 32'd6, 64'd12, 32, "post_rst");

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] av, bv;
            av = $urandom;
            bv = $urandom >> $urandom_range(0, 31);
            run_pair(av, bv);
        end

        chkint("add_sna_zero", int'(sna_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
